// File: rtl/matmul_calc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : matmul_calc_pkg
//  Description : Shared constants and types for the matmul accelerator and
//                its APB requester (bus widths, APB master FSM states,
//                request record).
//  Revision    : 1.0 - initial release
// ============================================================================
package matmul_calc_pkg;

    // APB data and address widths used across the matmul subsystem
    localparam int BUS_WIDTH  = 32;
    localparam int ADDR_WIDTH = 16;

    // APB requester FSM states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_IDLE = 2'd1,
        SETUP     = 2'd2,
        ACCESS    = 2'd3
    } apb_mst_state_t;

    // One request as presented on the valid/ready channel
    typedef struct packed {
        logic                   write;
        logic [ADDR_WIDTH-1:0]  addr;
        logic [BUS_WIDTH-1:0]   wdata;
        logic [BUS_WIDTH/8-1:0] strb;
        logic                   wait_idle;
    } apb_req_t;

endpackage
`default_nettype wire

// File: rtl/matmul_apb_master.sv
`default_nettype none
// ============================================================================
//  Module      : matmul_apb_master
//  Description : APB initiator for the matmul register port. Turns a
//                valid/ready request into SETUP/ACCESS transfers, optionally
//                waits for the accelerator to go idle first, and aborts a
//                transfer whose slave stalls longer than TIMEOUT_CYCLES.
//  Revision    : 1.0 - initial release
// ============================================================================
module matmul_apb_master
    import matmul_calc_pkg::*;
#(
    parameter int DATA_WIDTH     = matmul_calc_pkg::BUS_WIDTH,
    parameter int ADDR_WIDTH     = matmul_calc_pkg::ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    // request channel
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_write_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] req_strb_i,
    input  logic                    req_wait_idle_i,
    // response channel
    output logic                    rsp_valid_o,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    rsp_timeout_o,
    // APB requester
    output logic                    psel_o,
    output logic                    penable_o,
    output logic                    pwrite_o,
    output logic [ADDR_WIDTH-1:0]   paddr_o,
    output logic [DATA_WIDTH-1:0]   pwdata_o,
    output logic [DATA_WIDTH/8-1:0] pstrb_o,
    input  logic                    pready_i,
    input  logic                    pslverr_i,
    input  logic [DATA_WIDTH-1:0]   prdata_i,
    // accelerator status
    input  logic                    busy_i
);

    // Stall counter sized to hold TIMEOUT_CYCLES; a zero setting disables
    // the abort path entirely and leaves a 1-bit dummy counter.
    localparam int              CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    apb_mst_state_t          state;
    apb_mst_state_t          next_state;
    logic                    accept;
    logic                    done;
    logic                    timeout_hit;

    logic                    cur_write;
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic [DATA_WIDTH-1:0]   cur_wdata;
    logic [DATA_WIDTH/8-1:0] cur_strb;
    logic [CNT_W-1:0]        wait_cnt;

    logic                    rsp_valid;
    logic [DATA_WIDTH-1:0]   rsp_rdata;
    logic                    rsp_err;
    logic                    rsp_timeout;

    // Next-state logic plus the accept / completion / abort strobes.
    // The stall abort fires when this ACCESS cycle would be the
    // TIMEOUT_CYCLES-th one with pready low; pready high wins.
    always_comb begin
        next_state  = state;
        accept      = 1'b0;
        done        = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid_i) begin
                    accept     = 1'b1;
                    next_state = (req_wait_idle_i && busy_i) ? WAIT_IDLE : SETUP;
                end
            end
            WAIT_IDLE: begin
                if (!busy_i) begin
                    next_state = SETUP;
                end
            end
            SETUP: begin
                next_state = ACCESS;
            end
            ACCESS: begin
                if (pready_i) begin
                    done       = 1'b1;
                    next_state = IDLE;
                end else if (TIMEOUT_EN && (wait_cnt == CNT_LAST)) begin
                    timeout_hit = 1'b1;
                    next_state  = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register; reset drops psel/penable at once since they decode state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Capture the request on accept; read strobes are zeroed here so the
    // bus never shows a strobe on a read.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cur_write <= 1'b0;
            cur_addr  <= '0;
            cur_wdata <= '0;
            cur_strb  <= '0;
        end else if (accept) begin
            cur_write <= req_write_i;
            cur_addr  <= req_addr_i;
            cur_wdata <= req_wdata_i;
            cur_strb  <= req_write_i ? req_strb_i : '0;
        end
    end

    // Stall counter: cleared in SETUP, counts ACCESS cycles with pready low.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt <= '0;
        end else if (state == SETUP) begin
            wait_cnt <= '0;
        end else if ((state == ACCESS) && !pready_i) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Response register: one-cycle valid pulse per completed or aborted transfer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= done | timeout_hit;
            if (done) begin
                rsp_rdata   <= cur_write ? '0 : prdata_i;
                rsp_err     <= pslverr_i;
                rsp_timeout <= 1'b0;
            end else if (timeout_hit) begin
                rsp_rdata   <= '0;
                rsp_err     <= 1'b1;
                rsp_timeout <= 1'b1;
            end
        end
    end

    assign req_ready_o   = (state == IDLE);
    assign psel_o        = (state == SETUP) || (state == ACCESS);
    assign penable_o     = (state == ACCESS);
    assign pwrite_o      = cur_write;
    assign paddr_o       = cur_addr;
    assign pwdata_o      = cur_wdata;
    assign pstrb_o       = cur_strb;
    assign rsp_valid_o   = rsp_valid;
    assign rsp_rdata_o   = rsp_rdata;
    assign rsp_err_o     = rsp_err;
    assign rsp_timeout_o = rsp_timeout;

endmodule
`default_nettype wire

// File: tb/tb_matmul_apb_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matmul_apb_master
//  Description : Self-checking bench for matmul_apb_master. Each directed
//                transfer is turned into a per-cycle expected timeline
//                (accept, optional busy wait, SETUP, ACCESS cycles, response)
//                which a negedge process compares against the DUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_matmul_apb_master;
    import matmul_calc_pkg::*;

    localparam int DW   = BUS_WIDTH;
    localparam int AW   = ADDR_WIDTH;
    localparam int TO   = 4;
    localparam int MAXC = 1024;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_valid, req_ready, req_write, req_wait_idle;
    logic [AW-1:0]   req_addr;
    logic [DW-1:0]   req_wdata;
    logic [DW/8-1:0] req_strb;
    logic            rsp_valid, rsp_err, rsp_timeout;
    logic [DW-1:0]   rsp_rdata;
    logic            psel, penable, pwrite, pready, pslverr, busy;
    logic [AW-1:0]   paddr;
    logic [DW-1:0]   pwdata, prdata;
    logic [DW/8-1:0] pstrb;

    matmul_apb_master #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_write_i     (req_write),
        .req_addr_i      (req_addr),
        .req_wdata_i     (req_wdata),
        .req_strb_i      (req_strb),
        .req_wait_idle_i (req_wait_idle),
        .rsp_valid_o     (rsp_valid),
        .rsp_rdata_o     (rsp_rdata),
        .rsp_err_o       (rsp_err),
        .rsp_timeout_o   (rsp_timeout),
        .psel_o          (psel),
        .penable_o       (penable),
        .pwrite_o        (pwrite),
        .paddr_o         (paddr),
        .pwdata_o        (pwdata),
        .pstrb_o         (pstrb),
        .pready_i        (pready),
        .pslverr_i       (pslverr),
        .prdata_i        (prdata),
        .busy_i          (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // expected timeline, one entry per cycle
    bit              e_psel [MAXC];
    bit              e_pen  [MAXC];
    bit              e_rdy  [MAXC];
    bit              e_rspv [MAXC];
    bit              e_bus  [MAXC];
    bit              e_rsp  [MAXC];
    logic [AW-1:0]   e_addr [MAXC];
    logic [DW-1:0]   e_wdat [MAXC];
    logic [DW/8-1:0] e_strb [MAXC];
    bit              e_wr   [MAXC];
    logic [DW-1:0]   e_rdat [MAXC];
    bit              e_err  [MAXC];
    bit              e_tmo  [MAXC];

    int            last_rsp_cyc = -1;
    logic [DW-1:0] last_rdata;
    logic          last_err, last_tmo;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the expected timeline
    always @(negedge clk) begin
        if (chk_en && cyc < MAXC) begin
            chk("psel",      {31'd0, psel},      {31'd0, e_psel[cyc]});
            chk("penable",   {31'd0, penable},   {31'd0, e_pen[cyc]});
            chk("req_ready", {31'd0, req_ready}, {31'd0, e_rdy[cyc]});
            chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, e_rspv[cyc]});
            if (e_bus[cyc]) begin
                chk("paddr",  {16'd0, paddr},  {16'd0, e_addr[cyc]});
                chk("pwdata", pwdata,          e_wdat[cyc]);
                chk("pstrb",  {28'd0, pstrb},  {28'd0, e_strb[cyc]});
                chk("pwrite", {31'd0, pwrite}, {31'd0, e_wr[cyc]});
            end
            if (e_rsp[cyc]) begin
                chk("rsp_rdata",   rsp_rdata,              e_rdat[cyc]);
                chk("rsp_err",     {31'd0, rsp_err},       {31'd0, e_err[cyc]});
                chk("rsp_timeout", {31'd0, rsp_timeout},   {31'd0, e_tmo[cyc]});
            end
            if (rsp_valid) begin
                last_rsp_cyc = cyc;
                last_rdata   = rsp_rdata;
                last_err     = rsp_err;
                last_tmo     = rsp_timeout;
            end
        end
    end

    task automatic clear_inputs();
        req_valid = 1'b0; req_write = 1'b0; req_wait_idle = 1'b0;
        req_addr = '0; req_wdata = '0; req_strb = '0;
        pready = 1'b0; pslverr = 1'b0; prdata = '0; busy = 1'b0;
    endtask

    task automatic idle(input int k);
        clear_inputs();
        repeat (k) begin
            @(posedge clk); #1;
        end
    endtask

    // One transfer accepted in the current cycle n. bc = cycles busy is held
    // high from n, ws = ACCESS wait states, to = slave never answers.
    // Returns in the response cycle so the next call can be back-to-back.
    task automatic do_xfer(input apb_req_t r, input int bc, input int ws, input bit to,
                           input logic [DW-1:0] rd, input logic err, output int n);
        int s, a, rc, rdy_c;
        n     = cyc;
        s     = n + 1 + ((r.wait_idle && bc > 0) ? bc : 0);
        a     = to ? TO : ws + 1;
        rc    = s + 1 + a;
        rdy_c = to ? -1 : s + 1 + ws;
        for (int c = n + 1; c <= rc; c++) begin
            e_rdy[c]  = (c == rc);
            e_psel[c] = (c >= s) && (c < rc);
            e_pen[c]  = (c > s) && (c < rc);
            e_bus[c]  = 1'b1;
            e_addr[c] = r.addr;
            e_wdat[c] = r.wdata;
            e_strb[c] = r.write ? r.strb : '0;
            e_wr[c]   = r.write;
            e_rspv[c] = (c == rc);
            e_rsp[c]  = (c == rc);
            e_rdat[c] = (to || r.write) ? '0 : rd;
            e_err[c]  = to ? 1'b1 : err;
            e_tmo[c]  = to;
        end
        for (int c = n; c < rc; c++) begin
            req_valid     = (c == n);
            req_write     = r.write;
            req_addr      = r.addr;
            req_wdata     = r.wdata;
            req_strb      = r.strb;
            req_wait_idle = r.wait_idle;
            busy          = (c - n) < bc;
            pready        = (c == rdy_c);
            pslverr       = (c == rdy_c) ? err : 1'b0;
            prdata        = (c == rdy_c) ? (r.write ? 32'hBAD0_BAD0 : rd) : 32'h0;
            @(posedge clk); #1;
        end
        clear_inputs();
    endtask

    initial begin
        apb_req_t r;
        int n, n1, n2;
        for (int c = 0; c < MAXC; c++) begin
            e_psel[c] = 0; e_pen[c] = 0; e_rdy[c] = 1; e_rspv[c] = 0;
            e_bus[c] = 0; e_rsp[c] = 0; e_addr[c] = '0; e_wdat[c] = '0;
            e_strb[c] = '0; e_wr[c] = 0; e_rdat[c] = '0; e_err[c] = 0; e_tmo[c] = 0;
        end
        clear_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_psel",    {31'd0, psel},        32'd0);
        chk("rst_penable", {31'd0, penable},     32'd0);
        chk("rst_ready",   {31'd0, req_ready},   32'd1);
        chk("rst_rspv",    {31'd0, rsp_valid},   32'd0);
        chk("rst_paddr",   {16'd0, paddr},       32'd0);
        chk("rst_pwdata",  pwdata,               32'd0);
        chk("rst_rdata",   rsp_rdata,            32'd0);
        chk("rst_err",     {30'd0, rsp_err, rsp_timeout}, 32'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        idle(2);

        // write, zero wait: response three cycles after accept
        r = '{write: 1'b1, addr: 16'h0010, wdata: 32'hDEAD_BEEF, strb: 4'hF, wait_idle: 1'b0};
        do_xfer(r, 0, 0, 1'b0, '0, 1'b0, n);
        idle(1);
        chk("wr_latency", last_rsp_cyc, n + 3);
        chk("wr_rdata",   last_rdata,   32'h0);

        // read with three wait states
        r = '{write: 1'b0, addr: 16'h0020, wdata: 32'hFFFF_FFFF, strb: 4'hF, wait_idle: 1'b0};
        do_xfer(r, 0, 3, 1'b0, 32'h1234_5678, 1'b0, n);
        idle(1);
        chk("rd3_latency", last_rsp_cyc, n + 6);
        chk("rd3_rdata",   last_rdata,   32'h1234_5678);

        // slave error on a read
        r = '{write: 1'b0, addr: 16'h0024, wdata: 32'h0, strb: 4'h0, wait_idle: 1'b0};
        do_xfer(r, 0, 1, 1'b0, 32'h0000_00AA, 1'b1, n);
        idle(1);
        chk("slverr_err", {31'd0, last_err}, 32'd1);
        chk("slverr_tmo", {31'd0, last_tmo}, 32'd0);

        // timeout: four ACCESS cycles, then abort
        r = '{write: 1'b0, addr: 16'h0028, wdata: 32'h0, strb: 4'h0, wait_idle: 1'b0};
        do_xfer(r, 0, 0, 1'b1, 32'h5555_5555, 1'b0, n);
        idle(1);
        chk("tmo_latency", last_rsp_cyc, n + 6);
        chk("tmo_flags",   {30'd0, last_err, last_tmo}, 32'd3);
        chk("tmo_rdata",   last_rdata, 32'h0);

        // pready arrives in the same cycle the stall limit is reached
        r = '{write: 1'b0, addr: 16'h002C, wdata: 32'h0, strb: 4'h0, wait_idle: 1'b0};
        do_xfer(r, 0, 3, 1'b0, 32'hCAFE_F00D, 1'b0, n);
        idle(1);
        chk("limit_tmo",   {31'd0, last_tmo}, 32'd0);
        chk("limit_rdata", last_rdata, 32'hCAFE_F00D);

        // busy gating for ten cycles
        r = '{write: 1'b1, addr: 16'h0030, wdata: 32'h0000_0001, strb: 4'h1, wait_idle: 1'b1};
        do_xfer(r, 10, 0, 1'b0, '0, 1'b0, n);
        idle(1);
        chk("busy_latency", last_rsp_cyc, n + 13);

        // wait_idle set but busy already low: straight to SETUP
        r = '{write: 1'b1, addr: 16'h0034, wdata: 32'h0000_0002, strb: 4'h3, wait_idle: 1'b1};
        do_xfer(r, 0, 0, 1'b0, '0, 1'b0, n);
        // busy high but wait_idle clear: busy is ignored
        r = '{write: 1'b1, addr: 16'h0038, wdata: 32'h0000_0003, strb: 4'h8, wait_idle: 1'b0};
        do_xfer(r, 5, 0, 1'b0, '0, 1'b0, n);
        idle(1);
        chk("nowait_latency", last_rsp_cyc, n + 3);

        // back-to-back: one transfer every three cycles
        r = '{write: 1'b1, addr: 16'h0040, wdata: 32'hA5A5_A5A5, strb: 4'hC, wait_idle: 1'b0};
        do_xfer(r, 0, 0, 1'b0, '0, 1'b0, n1);
        r = '{write: 1'b0, addr: 16'h0044, wdata: 32'h0, strb: 4'hF, wait_idle: 1'b0};
        do_xfer(r, 0, 0, 1'b0, 32'h0BAD_CAFE, 1'b0, n2);
        idle(1);
        chk("b2b_latency", last_rsp_cyc, n1 + 6);
        chk("b2b_rdata",   last_rdata,   32'h0BAD_CAFE);

        // reset during an ACCESS wait state
        chk_en        = 1'b0;
        req_valid     = 1'b1;
        req_write     = 1'b0;
        req_addr      = 16'h0048;
        @(posedge clk); #1;
        clear_inputs();
        @(posedge clk); #1;
        chk("prerst_access", {30'd0, psel, penable}, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async", {30'd0, psel, penable}, 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst_rspv", {31'd0, rsp_valid}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            chk("postrst_rspv",  {31'd0, rsp_valid}, 32'd0);
            chk("postrst_ready", {31'd0, req_ready}, 32'd1);
        end
        chk_en = 1'b1;

        // recovery transfer after reset
        r = '{write: 1'b1, addr: 16'h004C, wdata: 32'h1357_9BDF, strb: 4'hF, wait_idle: 1'b0};
        do_xfer(r, 0, 2, 1'b0, '0, 1'b0, n);
        idle(2);
        chk("recover_latency", last_rsp_cyc, n + 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/matmul_apb_master.md
# matmul_apb_master

APB initiator that drives the register port of the matmul accelerator: the requester side of the matmul APB interface. It converts a simple valid/ready request channel (from the testbench stimulus or an on-chip controller) into compliant APB SETUP/ACCESS transfers, returns read data and error status, and optionally waits for the accelerator's `busy_o` to drop before issuing a transfer. It bounds every transfer with a stall timeout so a hung slave cannot lock the requester.

## Interface
Parameters:
- `DATA_WIDTH`, default `BUS_WIDTH` from `matmul_calc_pkg`: APB data width in bits.
- `ADDR_WIDTH`, default `ADDR_WIDTH` from `matmul_calc_pkg`: APB address width in bits.
- `TIMEOUT_CYCLES`, default 256: maximum ACCESS cycles with `pready` low before abort. 0 disables the timeout.

Ports:
- `clk_i`  in  1  clock; all logic is on the rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `req_valid_i`  in  1  request present.
- `req_ready_o`  out  1  request accepted when both valid and ready are high.
- `req_write_i`  in  1  1 = write, 0 = read.
- `req_addr_i`  in  ADDR_WIDTH  target address.
- `req_wdata_i`  in  DATA_WIDTH  write data.
- `req_strb_i`  in  DATA_WIDTH/8  write byte strobes.
- `req_wait_idle_i`  in  1  hold the transfer until `busy_i` is low.
- `rsp_valid_o`  out  1  one-cycle response pulse.
- `rsp_rdata_o`  out  DATA_WIDTH  read data; 0 for writes and timeouts.
- `rsp_err_o`  out  1  `pslverr` seen or timeout.
- `rsp_timeout_o`  out  1  transfer aborted by timeout.
- `psel_o`, `penable_o`, `pwrite_o`  out  1  APB controls.
- `paddr_o`  out  ADDR_WIDTH  APB address.
- `pwdata_o`  out  DATA_WIDTH  APB write data.
- `pstrb_o`  out  DATA_WIDTH/8  APB strobes.
- `pready_i`, `pslverr_i`  in  1  APB slave status.
- `prdata_i`  in  DATA_WIDTH  APB read data.
- `busy_i`  in  1  accelerator busy, from `busy_o`.

## Operation
- FSM states and transitions:
  - IDLE: go to WAIT_IDLE on accept if `req_wait_idle_i && busy_i`, otherwise go to SETUP on accept.
  - WAIT_IDLE: go to SETUP in the cycle after `busy_i` is sampled low. There is no timeout here.
  - SETUP: `psel=1`, `penable=0`. Go to ACCESS unconditionally.
  - ACCESS: `psel=1`, `penable=1`. On `pready_i`=1, go to IDLE and capture the response. On timeout, go to IDLE and report the abort.
- `req_ready_o` = (state == IDLE). It is combinational from state only and never depends on `req_valid_i`.
- The request is registered on accept. `paddr_o`, `pwrite_o`, `pwdata_o` and `pstrb_o` come from these registers and stay stable from SETUP through the end of ACCESS.
- On reads, `pstrb_o` is forced to 0.
- Outside a transfer, `paddr_o`, `pwdata_o` and `pstrb_o` hold their last values.
- Response capture on completion:
  - `rsp_rdata_o` = `prdata_i` for reads, 0 for writes.
  - `rsp_err_o` = `pslverr_i`.
  - `rsp_timeout_o` = 0.
- Timeout:
  - The counter clears on entering ACCESS and increments each ACCESS cycle with `pready_i` low.
  - When the count reaches `TIMEOUT_CYCLES`, `psel`/`penable` drop next cycle.
  - The response reports `rsp_err_o`=1, `rsp_timeout_o`=1, `rsp_rdata_o`=0.
  - A `pready_i` that is high in the same cycle the count reaches its limit takes priority: the transfer completes normally.
- The response has no back-pressure. The consumer must accept `rsp_valid_o` in the cycle it is asserted.

## Timing
- Reset values: state IDLE. All outputs are 0 except `req_ready_o`, which is 1. The response registers clear.
- Zero-wait transfer:
  - Cycle N: accept.
  - N+1: SETUP.
  - N+2: ACCESS, with `pready` high.
  - N+3: `rsp_valid_o`=1 and `req_ready_o`=1 together.
- Back-to-back throughput is one transfer per 3 cycles. Each wait state adds 1 cycle.
- `rsp_valid_o` is high for exactly 1 cycle per accepted request. Responses are in order.
- An assertion of `rst_ni` mid-transfer clears the state to IDLE immediately and deasserts `psel`/`penable` asynchronously. No response is produced for the aborted request.
- `busy_i` falling in the accept cycle means no WAIT_IDLE: the next cycle is SETUP.

## Structure
- `matmul_calc_pkg` holds:
  - the `BUS_WIDTH` and `ADDR_WIDTH` constants;
  - the FSM state enum `apb_mst_state_t` (IDLE, WAIT_IDLE, SETUP, ACCESS);
  - a packed `apb_req_t` struct (write, addr, wdata, strb, wait_idle).
- Single module. The timeout counter is inline, with width `$clog2(TIMEOUT_CYCLES+1)`, minimum 1.
- The block connects to the matmul interface through the STIMULUS modport.

## Test plan
- Write, zero wait: write to addr 0x0010 with wdata 0xDEADBEEF and strb 0xF.
  - Required: `psel` rises at N+1 and `penable` at N+2, with `paddr`=0x0010 and `pwdata`=0xDEADBEEF.
  - Required: `rsp_valid` at N+3, `rsp_err`=0, `rsp_rdata`=0.
- Read, 3 wait states: slave holds `pready` low for 3 ACCESS cycles, then returns `prdata`=0x12345678.
  - Required: `pstrb`=0 throughout.
  - Required: `rsp_valid` at N+6 with `rsp_rdata`=0x12345678.
- Slave error: read with `pslverr`=1 at completion.
  - Required: `rsp_err`=1, `rsp_timeout`=0.
- Timeout: run with `TIMEOUT_CYCLES`=4 and `pready` never asserted.
  - Required: ACCESS lasts 4 cycles, then `psel` drops.
  - Required: `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0.
- Busy gating: issue a request with `req_wait_idle`=1 while `busy_i`=1 for 10 cycles.
  - Required: `psel` stays 0 while `busy_i` is high.
  - Required: SETUP occurs in the cycle after `busy_i` falls.
- Reset mid-ACCESS: pull `rst_ni` low during a wait state.
  - Required: `psel`/`penable`=0 immediately, no `rsp_valid`, and `req_ready`=1 after release.
